tremolo_mod: RTL
================

Name: tremolo_mod

Overview:
- Parametrised tremolo (amplitude-modulation) stage for the effect chain.
- Sits between the sample source and the next effect, driven by the per-sample valid strobe.
- Generates an internal LFO (triangle, square, ramp-up or ramp-down) from a phase accumulator and scales each sample by a depth-weighted gain.
- Adds over the earlier tremolo: parametrised widths, selectable waveform, sample handshake, defined bypass, fixed 2-cycle pipeline and an LFO observation port.

Parameters:
- DATA_W, 16: signed sample width.
- RATE_W, 3: rate code width.
- DEPTH_W, 4: depth code width.
- LFO_W, 8: unipolar LFO/gain fraction width.
- PHASE_W, 24: phase accumulator width; must be ≥ LFO_W+1.
- RATE_STEP, 350: phase increment per sample for rate code 0 (≈1 Hz at 48 kHz, 24-bit phase).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_signal  in  DATA_W  signed input sample.
- i_valid  in  1  input sample strobe; 1-cycle pulse per sample.
- i_sel  in  1  effect selected.
- i_start  in  1  start modulation.
- i_rate  in  RATE_W  rate code r; increment = (r+1)*RATE_STEP.
- i_depth  in  DEPTH_W  depth code d; all-ones means 100%.
- i_wave  in  2  waveform: 00 triangle, 01 square, 10 ramp up, 11 ramp down.
- o_signal  out  DATA_W  signed output sample.
- o_valid  out  1  output strobe.
- o_lfo  out  LFO_W  current LFO value u.

Behaviour:
- Reset (async, i_rst_n low):
  - state = IDLE.
  - phase, rate, depth and wave registers = 0.
  - Pipeline valids = 0, o_signal = 0, o_valid = 0.
  - Applies immediately, including mid-pipeline; in-flight samples are dropped.
- FSM (evaluated every clock):
  - IDLE: i_sel=1 → SEL.
  - SEL: latch i_rate/i_depth/i_wave every cycle while i_sel=1.
    - i_start=1 → RUN, phase cleared to 0. i_start has priority over i_sel=0; settings are not latched that cycle.
    - Else i_sel=0 → IDLE.
  - RUN: settings frozen.
    - i_sel=0 → IDLE (phase held).
    - Else i_start=1 → phase cleared to 0; stay in RUN.
- Phase accumulator:
  - Advances by (rate+1)*RATE_STEP, modulo 2^PHASE_W, only on cycles with i_valid=1 and state==RUN.
  - Held otherwise. A phase clear in the same cycle wins over the advance.
- LFO u, combinational from registered phase:
  - t = phase[PHASE_W-1]; m = phase[PHASE_W-2 -: LFO_W]; s = phase[PHASE_W-1 -: LFO_W].
  - Triangle: u = t ? ~m : m.
  - Square: u = t ? 0 : 2^LFO_W-1.
  - Ramp up: u = s.
  - Ramp down: u = ~s.
  - o_lfo = u at all times; 0 after reset.
- Gain:
  - d_eff = (d == all-ones) ? 2^DEPTH_W : d.
  - g = 2^LFO_W − ((d_eff*(2^LFO_W − u)) >> DEPTH_W), unsigned LFO_W+1 bits, range 0..2^LFO_W.
  - State ≠ RUN at stage-1 capture → g = 2^LFO_W (bypass).
- Pipeline:
  - Stage 1, on i_valid: register sample x, gain g, valid.
  - Stage 2: o_signal = (x*g) >>> LFO_W, using a signed DATA_W+LFO_W+1 product with floor (arithmetic) shift, truncated to DATA_W.
  - o_valid = stage-1 valid delayed one cycle.
  - Latency: exactly 2 clocks from i_valid to o_valid.
  - No overflow is possible (g ≤ 2^LFO_W). Bypass output equals input exactly.
- Back-to-back strobes (i_valid every cycle) are sustained. o_signal holds its last value when o_valid=0.
- The gain used is the one for the phase before that sample's advance.
- Gain is chosen by the state at the cycle the sample is captured; a state change affects only later samples.

Test Plan:
- Reset, IDLE, i_valid pulse with x=1234 → o_valid exactly 2 cycles later; o_signal=1234; o_lfo=0.
- SEL (d=0, wave=00) → start → RUN; 10 samples of x=−20000 → each output −20000; gain 256 throughout.
- PHASE_W=12, RATE_STEP=64, r=0, square, d=15, x=16000 continuous:
  - Samples 0–31 → 15937 (g=255).
  - Samples 32–63 → 0.
  - Sample 64 → 15937 (wrap).
- Triangle, d=8, phase 0: x=−16384 → −8192. x=−1 → −1 (floor shift). o_lfo rises by 8 per sample (PHASE_W=12 setup).
- i_valid only every 5th cycle → phase advances once per strobe only; o_lfo is unchanged between strobes.
- FSM/reset edges:
  - i_sel low in RUN → next sample bypassed.
  - i_start in RUN → o_lfo returns to 0.
  - i_rst_n low mid-pipeline → o_valid=0 immediately and no later stale output.

Source files
------------

// File: rtl/tremolo_if.sv
// Sample stream between the tremolo stage and its neighbours: input sample
// with its strobe, and the modulated output sample with its strobe.
interface tremolo_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] i_signal;
    logic              i_valid;
    logic [DATA_W-1:0] o_signal;
    logic              o_valid;

    modport master (output i_signal, output i_valid, input o_signal, input o_valid);
    modport slave  (input i_signal, input i_valid, output o_signal, output o_valid);
endinterface

// File: rtl/tremolo_mod.sv
// Tremolo stage: LFO from a phase accumulator, depth-weighted gain, and a
// fixed two-clock sample pipeline with an exact bypass outside RUN.
module tremolo_mod #(
    parameter int DATA_W    = 16,
    parameter int RATE_W    = 3,
    parameter int DEPTH_W   = 4,
    parameter int LFO_W     = 8,
    parameter int PHASE_W   = 24,
    parameter int RATE_STEP = 350
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    tremolo_if.slave           bus,
    input  logic               i_sel,
    input  logic               i_start,
    input  logic [RATE_W-1:0]  i_rate,
    input  logic [DEPTH_W-1:0] i_depth,
    input  logic [1:0]         i_wave,
    output logic [LFO_W-1:0]   o_lfo
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEL = 2'd1, ST_RUN = 2'd2} state_t;

    localparam logic [PHASE_W-1:0] STEP     = PHASE_W'(RATE_STEP);
    localparam logic [LFO_W:0]     G_UNITY  = {1'b1, {LFO_W{1'b0}}};

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d, inc_s;
    logic [RATE_W-1:0]    rate_q;
    logic [DEPTH_W-1:0]   depth_q;
    logic [1:0]           wave_q;
    logic                 phase_clr_s, latch_s, run_s;
    logic [LFO_W-1:0]     lfo_s, tri_m_s, ramp_s;
    logic                 tri_t_s;
    logic [DEPTH_W:0]     d_eff_s;
    logic [LFO_W:0]       diff_s, g_s;
    logic [DEPTH_W+LFO_W:0] att_prod_s;
    logic [DATA_W-1:0]    x_q;
    logic [LFO_W:0]       g_q;
    logic                 v1_q, v2_q;
    logic [DATA_W-1:0]    sig_q, sig_d;
    logic signed [DATA_W+LFO_W:0] mul_s;

    assign run_s = (state_q == ST_RUN);

    // Mode sequencing; start outranks deselect while selecting
    always_comb begin
        state_d     = state_q;
        phase_clr_s = 1'b0;
        latch_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_sel) state_d = ST_SEL;
                else       state_d = ST_IDLE;
            end
            ST_SEL: begin
                if (i_start) begin
                    state_d     = ST_RUN;
                    phase_clr_s = 1'b1;
                end else if (!i_sel) begin
                    state_d = ST_IDLE;
                end else begin
                    latch_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (!i_sel)       state_d = ST_IDLE;
                else if (i_start) phase_clr_s = 1'b1;
                else              state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign inc_s = (PHASE_W'(rate_q) + PHASE_W'(1)) * STEP;

    // Phase advances once per strobe in RUN; a clear beats the advance
    always_comb begin
        if (phase_clr_s)                 phase_d = {PHASE_W{1'b0}};
        else if (bus.i_valid && run_s)   phase_d = phase_q + inc_s;
        else                             phase_d = phase_q;
    end

    assign tri_t_s = phase_q[PHASE_W-1];
    assign tri_m_s = phase_q[PHASE_W-2 -: LFO_W];
    assign ramp_s  = phase_q[PHASE_W-1 -: LFO_W];

    // Waveform shaping of the unipolar LFO
    always_comb begin
        lfo_s = {LFO_W{1'b0}};
        case (wave_q)
            2'b00:   lfo_s = tri_t_s ? ~tri_m_s : tri_m_s;
            2'b01:   lfo_s = tri_t_s ? {LFO_W{1'b0}} : {LFO_W{1'b1}};
            2'b10:   lfo_s = ramp_s;
            2'b11:   lfo_s = ~ramp_s;
            default: lfo_s = {LFO_W{1'b0}};
        endcase
    end

    // Full-scale depth code maps to exactly 2^DEPTH_W so 100% reaches zero gain
    assign d_eff_s    = (depth_q == {DEPTH_W{1'b1}}) ? {1'b1, {DEPTH_W{1'b0}}} : {1'b0, depth_q};
    assign diff_s     = G_UNITY - {1'b0, lfo_s};
    assign att_prod_s = {{LFO_W{1'b0}}, d_eff_s} * {{DEPTH_W{1'b0}}, diff_s};
    assign g_s        = G_UNITY - (LFO_W+1)'(att_prod_s >> DEPTH_W);

    assign mul_s = $signed({{(LFO_W+1){x_q[DATA_W-1]}}, x_q}) * $signed({{DATA_W{1'b0}}, g_q});
    assign sig_d = DATA_W'(mul_s >>> LFO_W);

    // State, phase and settings registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= {PHASE_W{1'b0}};
            rate_q  <= {RATE_W{1'b0}};
            depth_q <= {DEPTH_W{1'b0}};
            wave_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (latch_s) begin
                rate_q  <= i_rate;
                depth_q <= i_depth;
                wave_q  <= i_wave;
            end
        end
    end

    // Two-stage sample pipeline; gain is frozen at capture time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q   <= {DATA_W{1'b0}};
            g_q   <= {(LFO_W+1){1'b0}};
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            sig_q <= {DATA_W{1'b0}};
        end else begin
            v1_q <= bus.i_valid;
            v2_q <= v1_q;
            if (bus.i_valid) begin
                x_q <= bus.i_signal;
                g_q <= run_s ? g_s : G_UNITY;
            end
            if (v1_q) sig_q <= sig_d;
        end
    end

    assign bus.o_signal = sig_q;
    assign bus.o_valid  = v2_q;
    assign o_lfo        = lfo_s;
endmodule
